// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
// Shared definitions for the activation pipeline:
//   act_mode_e  - per-sample function select (ACT_TANH / ACT_SIGMOID)
//   SAT_DEFAULT - default saturation magnitude threshold (3.0 in Q16.16)
//   one(q)      - the value 1.0 in a Q format with q fractional bits
// ---------------------------------------------------------------------------
package act_pkg;

    typedef enum logic {
        ACT_TANH    = 1'b0,
        ACT_SIGMOID = 1'b1
    } act_mode_e;

    localparam logic [31:0] SAT_DEFAULT = 32'h0003_0000;

    function automatic logic [63:0] one(input int unsigned q);
        return 64'd1 << q;
    endfunction

endpackage

// File: rtl/act_rom.sv
// ---------------------------------------------------------------------------
// act_rom
// Dual-read synchronous ROM holding the positive half of tanh.
// Entry k = round(tanh(k * 2^(FB-Q)) * 2^Q); contents are generated at
// elaboration from that formula, so no data file has to travel with the core.
// Ports:
//   clk     - clock
//   en_i    - read enable (pipeline advance); outputs hold when low
//   addr_i  - first read address
//   rd_a_o  - mem[addr_i], registered
//   rd_b_o  - mem[min(addr_i+1, 2^AW-1)], registered
// ---------------------------------------------------------------------------
module act_rom #(
    parameter int AW = 10,
    parameter int N  = 32,
    parameter int Q  = 16,
    parameter int FB = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    output logic [N-1:0]  rd_a_o,
    output logic [N-1:0]  rd_b_o
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] ADDR_MAX = '1;

    function automatic logic [N-1:0] tanh_entry(input int k);
        real x;
        x = real'(k) * (2.0 ** (FB - Q));
        return N'($rtoi($tanh(x) * (2.0 ** Q) + 0.5));
    endfunction

    logic [N-1:0]  rom_mem [DEPTH];
    logic [AW-1:0] addr_b;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom_mem[gi] = tanh_entry(gi);
    end

    // The neighbour address clamps at the top entry instead of wrapping to 0.
    assign addr_b = (addr_i == ADDR_MAX) ? addr_i : addr_i + AW'(1);

    always_ff @(posedge clk) begin
        if (en_i) begin
            rd_a_o <= rom_mem[addr_i];
            rd_b_o <= rom_mem[addr_b];
        end
    end

endmodule

// File: rtl/act_lut_pipe.sv
// ---------------------------------------------------------------------------
// act_lut_pipe
// Three-stage fixed-point tanh / sigmoid unit (ROM + linear interpolation)
// with valid/ready handshake and a pass-through channel tag.
//   S1: pre-scale (sigmoid uses x/2), sign/magnitude split, saturation test
//   S2: ROM read of the two neighbouring entries
//   S3: interpolation, sign restore, sigmoid = (1 + tanh(x/2)) / 2
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake
//   in_data, in_mode    - sample (signed Q), 0 = tanh, 1 = sigmoid
//   in_tag              - channel tag carried with the sample
//   out_valid/out_ready - output handshake
//   out_data, out_tag   - result (signed Q) and its tag
//   out_sat             - result came from the saturation path
// ---------------------------------------------------------------------------
module act_lut_pipe
    import act_pkg::*;
#(
    parameter int           N   = 32,
    parameter int           Q   = 16,
    parameter int           AW  = 10,
    parameter int           FB  = 8,
    parameter logic [N-1:0] SAT = N'(SAT_DEFAULT),
    parameter int           TW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_mode,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [TW-1:0] out_tag,
    output logic          out_sat
);

    localparam int           N2       = 2 * N;
    localparam int           FBW      = FB + 1;
    localparam logic [N-1:0] ONE      = N'(one(Q));
    localparam logic [FB:0]  STEP_ONE = FBW'(1) << FB;

    // Whole pipeline moves together; it only stalls when a finished result
    // is sitting at the output and downstream refuses it.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // ---------------- S1 ----------------
    logic [N-1:0]  s1_x_d, s1_mag_d;
    logic          s1_valid_q, s1_neg_q, s1_sat_q, s1_mode_q;
    logic [AW-1:0] s1_addr_q;
    logic [FB-1:0] s1_frac_q;
    logic [TW-1:0] s1_tag_q;

    always_comb begin
        s1_x_d = in_data;
        if (act_mode_e'(in_mode) == ACT_SIGMOID) begin
            s1_x_d = $signed(in_data) >>> 1;
        end
        // The most negative value negates to itself; read unsigned it is
        // 2^(N-1), which is always above SAT and so lands in saturation.
        s1_mag_d = s1_x_d[N-1] ? -s1_x_d : s1_x_d;
    end

    // ---------------- S2 ----------------
    logic          s2_valid_q, s2_neg_q, s2_sat_q, s2_mode_q;
    logic [FB-1:0] s2_frac_q;
    logic [TW-1:0] s2_tag_q;
    logic [N-1:0]  s2_la, s2_lb;

    act_rom #(
        .AW (AW),
        .N  (N),
        .Q  (Q),
        .FB (FB)
    ) u_rom (
        .clk    (clk),
        .en_i   (en),
        .addr_i (s1_addr_q),
        .rd_a_o (s2_la),
        .rd_b_o (s2_lb)
    );

    // ---------------- S3 ----------------
    logic [FB:0]   s3_w_lo;
    logic [N2-1:0] s3_acc;
    logic [N-1:0]  s3_t_d, s3_tt_d, s3_y_d;

    always_comb begin
        s3_w_lo = STEP_ONE - {1'b0, s2_frac_q};
        s3_acc  = N2'(s2_la) * N2'(s3_w_lo) + N2'(s2_lb) * N2'(s2_frac_q);
        s3_t_d  = s2_sat_q ? ONE : N'(s3_acc >> FB);
        s3_tt_d = s2_neg_q ? -s3_t_d : s3_t_d;
        s3_y_d  = s3_tt_d;
        if (act_mode_e'(s2_mode_q) == ACT_SIGMOID) begin
            s3_y_d = $signed(ONE + s3_tt_d) >>> 1;
        end
    end

    // Control and visible outputs: reset clears them, flushing anything
    // in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_sat    <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
            out_data   <= s3_y_d;
            out_tag    <= s2_tag_q;
            out_sat    <= s2_sat_q;
        end
    end

    // Datapath registers: only meaningful alongside their valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_neg_q  <= s1_x_d[N-1];
            s1_sat_q  <= (s1_mag_d >= SAT);
            s1_addr_q <= s1_mag_d[AW+FB-1:FB];
            s1_frac_q <= s1_mag_d[FB-1:0];
            s1_mode_q <= in_mode;
            s1_tag_q  <= in_tag;

            s2_neg_q  <= s1_neg_q;
            s2_sat_q  <= s1_sat_q;
            s2_frac_q <= s1_frac_q;
            s2_mode_q <= s1_mode_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

endmodule

// File: tb/tb_act_lut_pipe.sv
// ---------------------------------------------------------------------------
// tb_act_lut_pipe
// Self-checking bench for act_lut_pipe: directed values, backpressure,
// reset flush and a randomized stream checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_act_lut_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_sat;

    always #5 clk = ~clk;

    act_lut_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_sat   (out_sat)
    );

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   tbl [1024];
    int   tests_run = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   n_out     = 0;
    bit   check_lat = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: tanh table by definition, interpolation and the sigmoid
    // identity sigmoid(x) = (1 + tanh(x/2)) / 2 in plain integer arithmetic.
    function automatic void ref_model(input logic [31:0] x, input logic m,
                                      output logic [31:0] y, output logic s);
        longint v, mag, t, tv, idx, fr, nidx;
        v = longint'($signed(x));
        if (m) v = (v - (v & 1)) / 2;             // floor(x / 2)
        mag = (v < 0) ? -v : v;
        s   = (mag >= 196608);                    // 3.0
        if (s) begin
            t = 65536;
        end else begin
            idx  = mag / 256;
            fr   = mag % 256;
            nidx = (idx + 1 > 1023) ? 1023 : idx + 1;
            t = (longint'(tbl[int'(idx)]) * (256 - fr) + longint'(tbl[int'(nidx)]) * fr) / 256;
        end
        tv = (v < 0) ? -t : t;
        if (m) tv = (65536 + tv) / 2;
        y = 32'(tv);
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 14);
        if ($urandom_range(0, 1) == 1) v = -v;
        case ($urandom_range(0, 15))
            0: v = 32'h0003_0000;
            1: v = 32'h0002_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h0005_FFFF;
            4: v = 32'hFFFA_0000;
            5: v = 32'hFFFD_0001;
            default: ;
        endcase
        return v;
    endfunction

    // One clock: drive at negedge, observe 1 time unit later.
    task automatic step(input logic r, input logic iv, input logic [31:0] d,
                        input logic m, input logic [3:0] t, input logic ordy,
                        input bit use_exp, input logic [31:0] ey, input logic esat,
                        output bit took);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; in_mode = m; in_tag = t; out_ready = ordy;
        #1;
        cyc++;
        took = 0;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                check_eq("out_data", 64'(out_data), 64'(sb[0].y));
                check_eq("out_tag",  64'(out_tag),  64'(sb[0].tag));
                check_eq("out_sat",  64'(out_sat),  64'(sb[0].sat));
                if (out_ready) begin
                    if (check_lat) check_eq("latency", 64'(cyc - sb[0].acc), 64'd3);
                    $display("[TB] out tag=%0d data=%08h sat=%0d", out_tag, out_data, out_sat);
                    n_out++;
                    void'(sb.pop_front());
                end
            end
        end
        if (iv && in_ready && !r) begin
            e.tag = t;
            e.acc = cyc;
            if (use_exp) begin
                e.y = ey; e.sat = esat;
            end else begin
                ref_model(d, m, e.y, e.sat);
            end
            sb.push_back(e);
            took = 1;
        end
    endtask

    task automatic idle(input logic ordy);
        bit tk;
        step(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, ordy, 1'b0, 32'd0, 1'b0, tk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1'b1);
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] dir_x [9] = '{32'h0000_0000, 32'h0000_0080, 32'hFFFF_FF80,
                               32'h0003_0000, 32'hFFFC_0000, 32'h8000_0000,
                               32'h0000_0000, 32'h0008_0000, 32'hFFF8_0000};
    logic        dir_m [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] dir_y [9] = '{32'h0000_0000, 32'h0000_0080, 32'hFFFF_FF80,
                               32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                               32'h0000_8000, 32'h0001_0000, 32'h0000_0000};
    logic        dir_s [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        bit tk;
        int idx;
        int k;
        for (int i = 0; i < 1024; i++) tbl[i] = $rtoi($tanh(real'(i) / 256.0) * 65536.0 + 0.5);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_tag",   64'(out_tag),   64'd0);
        check_eq("rst_out_sat",   64'(out_sat),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);

        // Directed values, one at a time, with latency check.
        check_lat = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, dir_x[i], dir_m[i], 4'(i), 1'b1, 1'b1, dir_y[i], dir_s[i], tk);
            repeat (4) idle(1'b1);
        end
        drain();

        // Back-to-back mixed modes: one per cycle, latency still 3.
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, rand_x(), i[0], 4'(i), 1'b1, 1'b0, 32'd0, 1'b0, tk);
        drain();
        check_lat = 0;

        // Backpressure: 8 samples, tags 0..7, output stalled 5 cycles mid-stream.
        n_out = 0; idx = 0; k = 0;
        while (idx < 8 && k < 100) begin
            step(1'b0, 1'b1, rand_x(), idx[0], 4'(idx), !(k >= 4 && k < 9), 1'b0, 32'd0, 1'b0, tk);
            if (tk) idx++;
            k++;
        end
        check_eq("bp_accepted", 64'(idx), 64'd8);
        drain();
        check_eq("bp_count", 64'(n_out), 64'd8);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'b0, $urandom_range(0, 3) != 0, rand_x(), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, 1'b0, 32'd0, 1'b0, tk);
        drain();

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, rand_x(), i[0], 4'(i + 5), 1'b1, 1'b0, 32'd0, 1'b0, tk);
        step(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, tk);
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check_eq("flush_valid", 64'(out_valid), 64'd0);
        end
        check_lat = 1;
        step(1'b0, 1'b1, 32'h0000_0080, 1'b0, 4'd9, 1'b1, 1'b1, 32'h0000_0080, 1'b0, tk);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
